nand3_vector_checker: RTL and testbench
=======================================

// Module: nand3_vector_checker
// PURPOSE
// Exhaustive functional checker for one NAND3X1 cell instance on the test die.
// Drives the cell's A/B/C inputs through all 8 vectors from registered outputs.
// Waits a programmable settle time after each vector, then samples Y and compares it with ~(A&B&C).
// Sits beside the cell under test: feeds it as the upstream stage and consumes Y as the downstream stage.
// PARAMETERS
// SETTLE_CYCLES  2  idle cycles between driving a vector and sampling Y (0 is legal)
// ERR_W          4  width of the saturating error counter
// PORTS
// CLK       in   1      rising-edge clock
// R         in   1      asynchronous, active-low reset
// START     in   1      pulse: begin a run (accepted only in IDLE)
// ABORT     in   1      synchronous abort: return to IDLE without DONE
// Y_IN      in   1      Y output of the cell under test
// A_OUT     out  1      drives cell input A (vector bit 2)
// B_OUT     out  1      drives cell input B (vector bit 1)
// C_OUT     out  1      drives cell input C (vector bit 0)
// BUSY      out  1      high from the cycle after START until DONE or abort
// DONE      out  1      one-cycle pulse when the run completes
// PASS      out  1      held high after a run with zero errors; cleared by START, ABORT or R
// ERR_CNT   out  ERR_W  mismatch count; saturates at all-ones
// FAIL_VLD  out  1      high once any mismatch has been recorded in this run
// FAIL_VEC  out  3      first mismatching vector {A,B,C}; valid only when FAIL_VLD=1
// BEHAVIOUR
// - Reset (R=0, async): all outputs 0, state=IDLE, vec=0, settle counter=0.
// - FSM states: IDLE, APPLY, SETTLE, SAMPLE, FIN.
//   - IDLE: START&!ABORT -> APPLY; vec<=0; ERR_CNT, FAIL_VLD, FAIL_VEC, PASS <= 0.
//   - APPLY: {A_OUT,B_OUT,C_OUT}<=vec. Goes to SETTLE, or to SAMPLE directly when SETTLE_CYCLES=0.
//   - SETTLE: stays exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
//   - SAMPLE: compares Y_IN with ~&vec. On mismatch: ERR_CNT++ (saturating); if !FAIL_VLD then FAIL_VLD<=1, FAIL_VEC<=vec.
//     Then: vec==7 -> FIN; otherwise vec++ and go to APPLY.
//   - FIN: DONE=1 for one cycle; PASS<=(no mismatch in run, including this sample); go to IDLE.
// - Each vector takes SETTLE_CYCLES+2 cycles. DONE rises 8*(SETTLE_CYCLES+2)+1 cycles after the START edge.
// - The cell inputs are stable from APPLY through SAMPLE; A/B/C change only in APPLY.
// - BUSY=1 in APPLY, SETTLE, SAMPLE and FIN.
// - START outside IDLE is ignored.
// - ABORT in any non-IDLE state -> IDLE next cycle:
//   - BUSY=0, PASS=0, no DONE, A/B/C<=0.
//   - ERR_CNT, FAIL_VLD and FAIL_VEC keep their values.
// - ABORT and START in the same IDLE cycle: ABORT wins, stay IDLE.
// - ERR_CNT at 2^ERR_W-1 stays there on further mismatches.
// - vec is 3 bits and never wraps inside a run: FIN is taken at vec==7.
// - Y_IN is sampled directly in CLK domain. The cell's combinational path lies inside the settle window; no synchroniser.
// STRUCTURE
// - Package nand3_chk_pkg holds:
//   - state_e enum {IDLE,APPLY,SETTLE,SAMPLE,FIN};
//   - VEC_W=3 and NUM_VECS=8;
//   - function golden_nand3(vec) returning ~&vec.
// - One sub-module: settle_timer, a loadable down-counter that outputs expired.
//   - It is loaded in APPLY. It is sized $clog2(SETTLE_CYCLES+1), minimum 1 bit.
// TESTING
// 1 Ideal NAND3 model, SETTLE_CYCLES=2, START -> DONE at cycle 33, PASS=1, ERR_CNT=0, FAIL_VLD=0.
// 2 Y_IN stuck at 1 -> one mismatch only; ERR_CNT=1, FAIL_VEC=3'b111, PASS=0.
// 3 Y_IN stuck at 0 with ERR_W=2 -> seven mismatches; ERR_CNT=3 (saturated), FAIL_VEC=3'b000.
// 4 Model delay of 3 cycles, SETTLE_CYCLES=1 -> ERR_CNT>0 and FAIL_VLD=1.
//   Same model delay with SETTLE_CYCLES=3 -> PASS=1.
// 5 ABORT while vec=3 -> IDLE next cycle, BUSY=0, A/B/C=0, no DONE pulse.
//   START in the same cycle as ABORT is ignored.
// 6 R low mid-SETTLE at vec=5 -> all outputs 0 immediately.
//   A new START after release gives a full 33-cycle run.

Source files
------------

// File: rtl/nand3_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nand3_chk_pkg
//  Purpose  : Shared types, vector constants and golden model for the NAND3 checker.
//  Revision : 1.0 - initial release
// ============================================================================
package nand3_chk_pkg;

   localparam int VEC_W    = 3;
   localparam int NUM_VECS = 8;
   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      FIN    = 3'd4
   } state_e;

   function automatic logic golden_nand3(input logic [VEC_W-1:0] vec);
      return ~&vec;
   endfunction

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : settle_timer
//  Purpose  : Loadable down-counter timing the settle window after each vector.
//  Revision : 1.0 - initial release
// ============================================================================
module settle_timer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_expired
);

   localparam int c_cnt_w = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   // Loading N-1 makes the window last exactly N cycles: the last one sees zero.
   localparam logic [c_cnt_w-1:0] c_load_val =
      (SETTLE_CYCLES > 0) ? c_cnt_w'(SETTLE_CYCLES - 1) : '0;

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= c_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/nand3_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module   : nand3_vector_checker
//  Purpose  : Walks a NAND3 cell through all 8 input vectors and checks its Y output.
//  Revision : 1.0 - initial release
// ============================================================================
module nand3_vector_checker
   import nand3_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_y_in,
   output logic             o_a_out,
   output logic             o_b_out,
   output logic             o_c_out,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic             o_fail_vld,
   output logic [VEC_W-1:0] o_fail_vec
);

   state_e             r_state;
   logic [VEC_W-1:0]   r_vec;
   logic [VEC_W-1:0]   r_abc;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;
   logic [ERR_W-1:0]   r_err_cnt;
   logic               r_fail_vld;
   logic [VEC_W-1:0]   r_fail_vec;

   logic               w_tmr_load;
   logic               w_tmr_en;
   logic               w_settle_done;
   logic               w_mismatch;

   assign w_tmr_load = (r_state == APPLY);
   assign w_tmr_en   = (r_state == SETTLE);
   assign w_mismatch = (i_y_in != golden_nand3(r_vec));

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_tmr_load),
      .i_en      (w_tmr_en),
      .o_expired (w_settle_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_vec      <= '0;
         r_abc      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_err_cnt  <= '0;
         r_fail_vld <= 1'b0;
         r_fail_vec <= '0;
      end else begin
         r_done <= 1'b0;
         // Abort keeps the error record so a partial run can still be inspected.
         if (i_abort && (r_state != IDLE)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_abc   <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (i_abort) begin
                     r_pass <= 1'b0;
                  end else if (i_start) begin
                     r_state    <= APPLY;
                     r_busy     <= 1'b1;
                     r_vec      <= '0;
                     r_pass     <= 1'b0;
                     r_err_cnt  <= '0;
                     r_fail_vld <= 1'b0;
                     r_fail_vec <= '0;
                  end
               end
               APPLY: begin
                  r_abc   <= r_vec;
                  r_state <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
               end
               SETTLE: begin
                  if (w_settle_done) begin
                     r_state <= SAMPLE;
                  end
               end
               SAMPLE: begin
                  if (w_mismatch) begin
                     if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + ERR_W'(1);
                     end
                     if (!r_fail_vld) begin
                        r_fail_vld <= 1'b1;
                        r_fail_vec <= r_vec;
                     end
                  end
                  if (r_vec == LAST_VEC) begin
                     r_state <= FIN;
                  end else begin
                     r_vec   <= r_vec + 1'b1;
                     r_state <= APPLY;
                  end
               end
               FIN: begin
                  r_done  <= 1'b1;
                  r_pass  <= !r_fail_vld;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_a_out    = r_abc[2];
   assign o_b_out    = r_abc[1];
   assign o_c_out    = r_abc[0];
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_pass     = r_pass;
   assign o_err_cnt  = r_err_cnt;
   assign o_fail_vld = r_fail_vld;
   assign o_fail_vec = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_nand3_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nand3_vector_checker
//  Purpose  : Directed self-checking bench for nand3_vector_checker in several configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nand3_vector_checker;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] ymode = 2'd0;   // 0 ideal cell, 1 stuck-at-1, 2 stuck-at-0
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   // u0: default configuration, selectable cell model
   logic a0, b0, c0, busy0, done0, pass0, fvld0, y0;
   logic [3:0]  err0;
   logic [2:0]  fvec0;
   logic [13:0] st0;
   assign y0  = (ymode == 2'd0) ? ~(a0 & b0 & c0) : (ymode == 2'd1);
   assign st0 = {busy0, done0, pass0, err0, fvld0, fvec0, a0, b0, c0};

   // u1: narrow error counter, cell stuck at 0
   logic a1, b1, c1, busy1, done1, pass1, fvld1;
   logic [1:0] err1;
   logic [2:0] fvec1;

   // u2 / u3: cell with a 3-cycle output delay, short and long settle windows
   logic a2, b2, c2, busy2, done2, pass2, fvld2;
   logic a3, b3, c3, busy3, done3, pass3, fvld3;
   logic [3:0] err2, err3;
   logic [2:0] fvec2, fvec3;
   logic [2:0] p2, p3;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p2 <= 3'b111;
         p3 <= 3'b111;
      end else begin
         p2 <= {p2[1:0], ~(a2 & b2 & c2)};
         p3 <= {p3[1:0], ~(a3 & b3 & c3)};
      end
   end

   // u4: zero settle cycles, ideal cell
   logic a4, b4, c4, busy4, done4, pass4, fvld4;
   logic [3:0] err4;
   logic [2:0] fvec4;

   nand3_vector_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) u0 (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_y_in(y0),
      .o_a_out(a0), .o_b_out(b0), .o_c_out(c0), .o_busy(busy0), .o_done(done0),
      .o_pass(pass0), .o_err_cnt(err0), .o_fail_vld(fvld0), .o_fail_vec(fvec0));

   nand3_vector_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_y_in(1'b0),
      .o_a_out(a1), .o_b_out(b1), .o_c_out(c1), .o_busy(busy1), .o_done(done1),
      .o_pass(pass1), .o_err_cnt(err1), .o_fail_vld(fvld1), .o_fail_vec(fvec1));

   nand3_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u2 (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_y_in(p2[2]),
      .o_a_out(a2), .o_b_out(b2), .o_c_out(c2), .o_busy(busy2), .o_done(done2),
      .o_pass(pass2), .o_err_cnt(err2), .o_fail_vld(fvld2), .o_fail_vec(fvec2));

   nand3_vector_checker #(.SETTLE_CYCLES(3), .ERR_W(4)) u3 (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_y_in(p3[2]),
      .o_a_out(a3), .o_b_out(b3), .o_c_out(c3), .o_busy(busy3), .o_done(done3),
      .o_pass(pass3), .o_err_cnt(err3), .o_fail_vld(fvld3), .o_fail_vec(fvec3));

   nand3_vector_checker #(.SETTLE_CYCLES(0), .ERR_W(4)) u4 (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_y_in(~(a4 & b4 & c4)),
      .o_a_out(a4), .o_b_out(b4), .o_c_out(c4), .o_busy(busy4), .o_done(done4),
      .o_pass(pass4), .o_err_cnt(err4), .o_fail_vld(fvld4), .o_fail_vec(fvec4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse START for exactly one edge; returns 1 ns after that edge.
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_vec++;
      if (st0 !== 14'd0) begin
         n_err++;
         $display("FAIL reset_state: got %h expected %h", st0, 14'd0);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ideal();
      logic [2:0] exp_abc;
      ymode = 2'd0;
      pulse_start();
      for (int n = 1; n <= 45; n++) begin
         tick();
         if (n <= 32) begin
            exp_abc = 3'((n - 1) / 4);
            n_vec++;
            if ({busy0, a0, b0, c0} !== {1'b1, exp_abc}) begin
               n_err++;
               $display("FAIL ideal_cycle%0d busy/abc: got %b expected %b",
                        n, {busy0, a0, b0, c0}, {1'b1, exp_abc});
            end
         end
         n_vec++;
         if (done0 !== (n == 33)) begin
            n_err++;
            $display("FAIL ideal_done_cycle%0d: got %b expected %b", n, done0, (n == 33));
         end
         n_vec++;
         if (done4 !== (n == 17)) begin
            n_err++;
            $display("FAIL zero_settle_done_cycle%0d: got %b expected %b", n, done4, (n == 17));
         end
      end
      n_vec++;
      if ({busy0, pass0, err0, fvld0} !== {1'b0, 1'b1, 4'd0, 1'b0}) begin
         n_err++;
         $display("FAIL ideal_result: got %b expected %b",
                  {busy0, pass0, err0, fvld0}, {1'b0, 1'b1, 4'd0, 1'b0});
      end
      n_vec++;
      if ({pass4, err4, fvld4} !== {1'b1, 4'd0, 1'b0}) begin
         n_err++;
         $display("FAIL zero_settle_result: got %b expected %b",
                  {pass4, err4, fvld4}, {1'b1, 4'd0, 1'b0});
      end
   endtask

   task automatic test_stuck_high();
      int cyc = 0;
      ymode = 2'd1;
      pulse_start();
      n_vec++;
      if ({busy0, pass0} !== 2'b10) begin
         n_err++;
         $display("FAIL start_clears_pass: got %b expected %b", {busy0, pass0}, 2'b10);
      end
      for (int n = 1; n <= 45; n++) begin
         tick();
         if (done0 && cyc == 0) cyc = n;
      end
      n_vec++;
      if (cyc !== 33) begin
         n_err++;
         $display("FAIL stuck1_done_cycle: got %0d expected %0d", cyc, 33);
      end
      n_vec++;
      if (st0[13:3] !== {1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 3'b111}) begin
         n_err++;
         $display("FAIL stuck1_result: got %b expected %b",
                  st0[13:3], {1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 3'b111});
      end
   endtask

   task automatic test_saturation();
      ymode = 2'd2;
      pulse_start();
      for (int n = 1; n <= 45; n++) begin
         tick();
         if (n == 16 || n == 20) begin
            n_vec++;
            if (err1 !== 2'd3) begin
               n_err++;
               $display("FAIL sat_cycle%0d err_w2: got %0d expected %0d", n, err1, 3);
            end
            n_vec++;
            if (err0 !== 4'(n / 4)) begin
               n_err++;
               $display("FAIL sat_cycle%0d err_w4: got %0d expected %0d", n, err0, n / 4);
            end
         end
      end
      n_vec++;
      if ({pass1, err1, fvld1, fvec1} !== {1'b0, 2'd3, 1'b1, 3'b000}) begin
         n_err++;
         $display("FAIL sat_w2_result: got %b expected %b",
                  {pass1, err1, fvld1, fvec1}, {1'b0, 2'd3, 1'b1, 3'b000});
      end
      n_vec++;
      if ({pass0, err0, fvld0, fvec0} !== {1'b0, 4'd7, 1'b1, 3'b000}) begin
         n_err++;
         $display("FAIL stuck0_w4_result: got %b expected %b",
                  {pass0, err0, fvld0, fvec0}, {1'b0, 4'd7, 1'b1, 3'b000});
      end
   endtask

   task automatic test_settle_window();
      int cyc3 = 0;
      pulse_start();
      for (int n = 1; n <= 45; n++) begin
         tick();
         if (done3 && cyc3 == 0) cyc3 = n;
      end
      n_vec++;
      if (!(err2 > 4'd0) || fvld2 !== 1'b1 || pass2 !== 1'b0) begin
         n_err++;
         $display("FAIL short_settle: got err=%0d fail_vld=%b pass=%b expected err>0 fail_vld=1 pass=0",
                  err2, fvld2, pass2);
      end
      n_vec++;
      if ({pass3, err3, fvld3} !== {1'b1, 4'd0, 1'b0}) begin
         n_err++;
         $display("FAIL long_settle: got %b expected %b", {pass3, err3, fvld3}, {1'b1, 4'd0, 1'b0});
      end
      n_vec++;
      if (cyc3 !== 41) begin
         n_err++;
         $display("FAIL long_settle_done_cycle: got %0d expected %0d", cyc3, 41);
      end
   endtask

   task automatic test_abort();
      ymode = 2'd2;
      pulse_start();
      for (int n = 1; n <= 13; n++) tick();
      n_vec++;
      if ({busy0, a0, b0, c0} !== 4'b1011) begin
         n_err++;
         $display("FAIL abort_pre_vec3: got %b expected %b", {busy0, a0, b0, c0}, 4'b1011);
      end
      abort = 1'b1;
      start = 1'b1;
      tick();
      n_vec++;
      if (st0 !== {1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 3'b000, 3'b000}) begin
         n_err++;
         $display("FAIL abort_state: got %b expected %b",
                  st0, {1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 3'b000, 3'b000});
      end
      tick();
      abort = 1'b0;
      start = 1'b0;
      for (int n = 1; n <= 45; n++) begin
         tick();
         n_vec++;
         if ({busy0, done0, err0} !== {1'b0, 1'b0, 4'd3}) begin
            n_err++;
            $display("FAIL abort_idle_cycle%0d: got %b expected %b",
                     n, {busy0, done0, err0}, {1'b0, 1'b0, 4'd3});
         end
      end
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      ymode = 2'd0;
      pulse_start();
      for (int n = 1; n <= 22; n++) tick();
      n_vec++;
      if ({busy0, a0, b0, c0} !== 4'b1101) begin
         n_err++;
         $display("FAIL pre_reset_vec5: got %b expected %b", {busy0, a0, b0, c0}, 4'b1101);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (st0 !== 14'd0) begin
         n_err++;
         $display("FAIL async_reset: got %h expected %h", st0, 14'd0);
      end
      #1;
      rst_n = 1'b1;
      tick();
      pulse_start();
      for (int n = 1; n <= 45; n++) begin
         tick();
         if (done0 && cyc == 0) cyc = n;
      end
      n_vec++;
      if (cyc !== 33) begin
         n_err++;
         $display("FAIL post_reset_done_cycle: got %0d expected %0d", cyc, 33);
      end
      n_vec++;
      if ({pass0, err0, fvld0} !== {1'b1, 4'd0, 1'b0}) begin
         n_err++;
         $display("FAIL post_reset_result: got %b expected %b",
                  {pass0, err0, fvld0}, {1'b1, 4'd0, 1'b0});
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stuck_high();
      test_saturation();
      test_settle_window();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
